// File: rtl/pipe_stage_regs_fde.sv
// F/D/E pipeline registers for the RV32I five-stage core, with hazard-unit
// hold/bubble semantics and saturating event counters.
module pipe_stage_regs_fde #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic [31:0]       PC_nextF,
  input  logic [31:0]       instrF,
  input  logic [31:0]       PCPlus4F,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [31:0]       rd1D,
  input  logic [31:0]       rd2D,
  input  logic [31:0]       immExtD,
  input  logic [4:0]        rs1D,
  input  logic [4:0]        rs2D,
  input  logic [4:0]        rdD,
  output logic [31:0]       PCF,
  output logic [31:0]       instrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  output logic              validD,
  output logic              validE,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [31:0]       rd1E,
  output logic [31:0]       rd2E,
  output logic [31:0]       immExtE,
  output logic [31:0]       PCE,
  output logic [31:0]       PCPlus4E,
  output logic [4:0]        rs1E,
  output logic [4:0]        rs2E,
  output logic [4:0]        rdE,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       redirect_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       issue_cnt
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

  // A redirect must win over a fetch stall, otherwise the target would be lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (!stallF || flushD) begin
      PCF <= PC_nextF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flushD) begin
      instrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else if (!stallD) begin
      instrD   <= instrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      validD   <= 1'b1;
    end
  end

  // Bubbles zero the register indices so they never match in forwarding or lw-stall checks.
  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      ctrlE    <= '0;
      rd1E     <= '0;
      rd2E     <= '0;
      immExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      rs1E     <= '0;
      rs2E     <= '0;
      rdE      <= '0;
      validE   <= 1'b0;
    end else begin
      ctrlE    <= ctrlD;
      rd1E     <= rd1D;
      rd2E     <= rd2D;
      immExtE  <= immExtD;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      rs1E     <= rs1D;
      rs2E     <= rs2D;
      rdE      <= rdD;
      validE   <= validD;
    end
  end

  // Redirect-driven flushes of E are excluded from the load-use bubble count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
      bubble_cnt   <= '0;
      issue_cnt    <= '0;
    end else begin
      if (stallD && !flushD) stall_cnt    <= satInc(stall_cnt);
      if (flushD)            redirect_cnt <= satInc(redirect_cnt);
      if (flushE && !flushD) bubble_cnt   <= satInc(bubble_cnt);
      if (validD && !flushE) issue_cnt    <= satInc(issue_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs_fde.sv
// Scoreboard bench for pipe_stage_regs_fde: the driver queues hand-computed
// post-edge state per cycle, a monitor pops and compares it after each edge.
module tb_pipe_stage_regs_fde;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, flushD, flushE;
  logic [31:0] PC_nextF, instrF, PCPlus4F;
  logic [15:0] ctrlD;
  logic [31:0] rd1D, rd2D, immExtD;
  logic [4:0]  rs1D, rs2D, rdD;
  logic [31:0] PCF, instrD, PCD, PCPlus4D;
  logic        validD, validE;
  logic [15:0] ctrlE;
  logic [31:0] rd1E, rd2E, immExtE, PCE, PCPlus4E;
  logic [4:0]  rs1E, rs2E, rdE;
  logic [31:0] stall_cnt, redirect_cnt, bubble_cnt, issue_cnt;

  typedef struct {
    string       tag;
    logic [31:0] pcf, instrD, pcd;
    logic        validD, validE;
    logic [4:0]  rdE;
    logic [15:0] ctrlE;
    logic [31:0] stallC, redirC, bubC, issC;
  } exp_t;

  exp_t sbQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  pipe_stage_regs_fde dut (
    .clk(clk), .reset(reset),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .PC_nextF(PC_nextF), .instrF(instrF), .PCPlus4F(PCPlus4F),
    .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .immExtD(immExtD),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .PCF(PCF), .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .validD(validD), .validE(validE),
    .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E), .immExtE(immExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt),
    .bubble_cnt(bubble_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mkExp(string tag, logic [31:0] pcf, logic [31:0] iD,
                                 logic [31:0] pcd, logic vD, logic vE,
                                 logic [4:0] rE, logic [15:0] cE,
                                 logic [31:0] sc, logic [31:0] rc,
                                 logic [31:0] bc, logic [31:0] ic);
    exp_t e;
    e.tag = tag; e.pcf = pcf; e.instrD = iD; e.pcd = pcd;
    e.validD = vD; e.validE = vE; e.rdE = rE; e.ctrlE = cE;
    e.stallC = sc; e.redirC = rc; e.bubC = bc; e.issC = ic;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expectation is owed for every edge the driver launched.
  always @(posedge clk) begin
    #2;
    if (sbQ.size() > 0) begin
      exp_t e;
      e = sbQ.pop_front();
      checkOutput({e.tag, ".PCF"},          PCF,                 e.pcf);
      checkOutput({e.tag, ".instrD"},       instrD,              e.instrD);
      checkOutput({e.tag, ".PCD"},          PCD,                 e.pcd);
      checkOutput({e.tag, ".validD"},       {31'd0, validD},     {31'd0, e.validD});
      checkOutput({e.tag, ".validE"},       {31'd0, validE},     {31'd0, e.validE});
      checkOutput({e.tag, ".rdE"},          {27'd0, rdE},        {27'd0, e.rdE});
      checkOutput({e.tag, ".ctrlE"},        {16'd0, ctrlE},      {16'd0, e.ctrlE});
      checkOutput({e.tag, ".stall_cnt"},    stall_cnt,           e.stallC);
      checkOutput({e.tag, ".redirect_cnt"}, redirect_cnt,        e.redirC);
      checkOutput({e.tag, ".bubble_cnt"},   bubble_cnt,          e.bubC);
      checkOutput({e.tag, ".issue_cnt"},    issue_cnt,           e.issC);
    end
  end

  task automatic applyStimulus(input exp_t e);
    sbQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setCtl(input logic sF, input logic sD, input logic fD, input logic fE);
    stallF = sF; stallD = sD; flushD = fD; flushE = fE;
  endtask

  task automatic setFetch(input logic [31:0] nextPc, input logic [31:0] instr,
                          input logic [31:0] plus4, input logic [15:0] ctrl,
                          input logic [4:0] rd);
    PC_nextF = nextPc; instrF = instr; PCPlus4F = plus4; ctrlD = ctrl; rdD = rd;
    rd1D = 32'h1111_0000 ^ {27'd0, rd}; rd2D = 32'h2222_0000; immExtD = 32'h0000_0004;
    rs1D = 5'd1; rs2D = 5'd2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    setCtl(1'b0, 1'b0, 1'b0, 1'b0);
    setFetch(32'h0, 32'h0, 32'h0, 16'h0, 5'd0);
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      setCtl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      setFetch($urandom, $urandom, $urandom, 16'($urandom), 5'($urandom));
      applyStimulus(mkExp("reset", 32'h0, 32'h13, 32'h0, 0, 0, 5'd0, 16'h0, 0, 0, 0, 0));
    end

    reset = 1'b0;
    setCtl(1'b0, 1'b0, 1'b0, 1'b0);
    setFetch(32'h4, 32'h0050_0093, 32'h4, 16'h0000, 5'd0);
    applyStimulus(mkExp("flow0", 32'h4, 32'h0050_0093, 32'h0, 1, 0, 5'd0, 16'h0, 0, 0, 0, 0));

    setFetch(32'h8, 32'h0010_0113, 32'h8, 16'h0081, 5'd1);
    applyStimulus(mkExp("flow1", 32'h8, 32'h0010_0113, 32'h4, 1, 1, 5'd1, 16'h0081, 0, 0, 0, 1));

    setCtl(1'b1, 1'b1, 1'b0, 1'b0);
    setFetch(32'hC, 32'h0020_8193, 32'hC, 16'h0042, 5'd2);
    applyStimulus(mkExp("luStall", 32'h8, 32'h0010_0113, 32'h4, 1, 1, 5'd2, 16'h0042, 1, 0, 0, 2));

    setCtl(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(mkExp("luBubble", 32'hC, 32'h0020_8193, 32'h8, 1, 0, 5'd0, 16'h0, 1, 0, 1, 2));

    setCtl(1'b0, 1'b0, 1'b1, 1'b1);
    setFetch(32'h40, 32'h0000_0463, 32'h10, 16'h0077, 5'd3);
    applyStimulus(mkExp("branch", 32'h40, 32'h13, 32'h0, 0, 0, 5'd0, 16'h0, 1, 1, 1, 2));

    setCtl(1'b0, 1'b0, 1'b0, 1'b0);
    setFetch(32'h44, 32'h0030_0213, 32'h44, 16'h0000, 5'd0);
    applyStimulus(mkExp("refetch", 32'h44, 32'h0030_0213, 32'h40, 1, 0, 5'd0, 16'h0, 1, 1, 1, 2));

    setCtl(1'b1, 1'b1, 1'b1, 1'b0);
    setFetch(32'h80, 32'h0040_0293, 32'h48, 16'h0011, 5'd4);
    applyStimulus(mkExp("stallVsFlush", 32'h80, 32'h13, 32'h0, 0, 1, 5'd4, 16'h0011, 1, 2, 1, 3));

    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    setCtl(1'b1, 1'b1, 1'b0, 1'b0);
    setFetch(32'h84, 32'h0050_0313, 32'h84, 16'h0000, 5'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkExp("saturate", 32'h80, 32'h13, 32'h0, 0, 0, 5'd0, 16'h0,
                          32'hFFFF_FFFF, 2, 1, 3));
    end

    reset = 1'b1;
    applyStimulus(mkExp("midReset", 32'h0, 32'h13, 32'h0, 0, 0, 5'd0, 16'h0, 0, 0, 0, 0));

    reset = 1'b0;
    setCtl(1'b0, 1'b0, 1'b0, 1'b0);
    setFetch(32'h4, 32'h0050_0093, 32'h4, 16'h0000, 5'd0);
    applyStimulus(mkExp("postReset", 32'h4, 32'h0050_0093, 32'h0, 1, 0, 5'd0, 16'h0, 0, 0, 0, 0));

    repeat (2) @(negedge clk);
    vectors++;
    if (sbQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", sbQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
